// File: rtl/spi_frame_slave_pkg.sv
// Shared types and frame-geometry helpers for the SPI debug frame slave.
package spi_frame_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_len(input int nb_addr, input int nb_data);
    return 1 + nb_addr + nb_data;
  endfunction

endpackage

// File: rtl/spi_frame_slave_sync_edge_det.sv
// Multi-flop synchronizer with registered-history rise/fall pulses.
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-0 slave decoding RW/address/data frames into register-file
// read and write accesses, oversampled in the clk domain.
module spi_frame_slave
  import spi_frame_slave_pkg::*;
#(
  parameter int NB_ADDR     = 7,
  parameter int NB_DATA     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  output logic [NB_ADDR-1:0] spi_addr,
  output logic [NB_DATA-1:0] spi_wdata,
  output logic               spi_wr_en,
  output logic               spi_ss_n,
  input  logic [NB_DATA-1:0] spi_rdata
);

  localparam int FRAME_LEN = frame_len(NB_ADDR, NB_DATA);
  localparam int CW        = $clog2(FRAME_LEN + 1);
  localparam int RX_W      = (NB_ADDR + 1 > NB_DATA) ? NB_ADDR + 1 : NB_DATA;

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(mosi),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RX_W-2:0]    rx_q, rx_d;
  logic [RX_W-1:0]    rx_new;
  logic [NB_DATA-1:0] tx_q, tx_d;
  logic [NB_ADDR-1:0] spi_addr_q, spi_addr_d;
  logic [NB_DATA-1:0] spi_wdata_q, spi_wdata_d;
  logic               spi_wr_en_q, spi_wr_en_d;
  logic               miso_q, miso_d;
  logic               rw_q, rw_d;
  logic               ld_tx_q, ld_tx_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    spi_addr_d  = spi_addr_q;
    spi_wdata_d = spi_wdata_q;
    spi_wr_en_d = 1'b0;
    miso_d      = miso_q;
    rw_d        = rw_q;
    ld_tx_d     = 1'b0;
    rx_new      = {rx_q, mosi_lvl};

    // spi_rdata reflects the address latched on the previous clk
    if (ld_tx_q) tx_d = spi_rdata;

    unique case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end
      end
      ST_CMD: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          rx_d = rx_new[RX_W-2:0];
          if (cnt_q == CW'(NB_ADDR)) begin
            state_d    = ST_DATA;
            cnt_d      = '0;
            spi_addr_d = rx_new[NB_ADDR-1:0];
            rw_d       = rx_new[NB_ADDR];
            ld_tx_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DATA: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end else if (sclk_rise) begin
          rx_d = rx_new[RX_W-2:0];
          if (cnt_q == CW'(NB_DATA - 1)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            miso_d  = 1'b0;
            if (rw_q == RW_WRITE) begin
              spi_wdata_d = rx_new[NB_DATA-1:0];
              spi_wr_en_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (sclk_fall && rw_q == RW_READ) begin
          miso_d = tx_q[NB_DATA-1];
          tx_d   = {tx_q[NB_DATA-2:0], 1'b0};
        end
      end
      ST_DONE: begin
        miso_d = 1'b0;
        if (cs_rise) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      spi_addr_q  <= '0;
      spi_wdata_q <= '0;
      spi_wr_en_q <= 1'b0;
      miso_q      <= 1'b0;
      rw_q        <= RW_READ;
      ld_tx_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      spi_addr_q  <= spi_addr_d;
      spi_wdata_q <= spi_wdata_d;
      spi_wr_en_q <= spi_wr_en_d;
      miso_q      <= miso_d;
      rw_q        <= rw_d;
      ld_tx_q     <= ld_tx_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = ~cs_lvl;
  assign spi_ss_n  = cs_lvl;
  assign spi_addr  = spi_addr_q;
  assign spi_wdata = spi_wdata_q;
  assign spi_wr_en = spi_wr_en_q;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Self-checking bench: SPI master tasks plus a write-strobe scoreboard.
module tb_spi_frame_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, spi_wr_en, spi_ss_n;
  logic [6:0] spi_addr;
  logic [7:0] spi_wdata;
  logic [7:0] spi_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  logic wr_prev = 1'b0;

  always #5 clk = ~clk;

  spi_frame_slave dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .spi_addr(spi_addr),
    .spi_wdata(spi_wdata), .spi_wr_en(spi_wr_en),
    .spi_ss_n(spi_ss_n), .spi_rdata(spi_rdata)
  );

  // register-file model
  always_comb begin
    spi_rdata = {1'b0, spi_addr} ^ 8'h5A;
    if (spi_addr == 7'h23) spi_rdata = 8'h3C;
  end

  always @(negedge clk) begin
    if (spi_wr_en === 1'b1) begin
      wr_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe got addr=%h data=%h want none",
                 spi_addr, spi_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({spi_addr, spi_wdata} !== {mon_e.a, mon_e.d}) begin
          n_fail++;
          $display("FAIL strobe_data got %h/%h want %h/%h",
                   spi_addr, spi_wdata, mon_e.a, mon_e.d);
        end
      end
      if (wr_prev === 1'b1) begin
        n_fail++;
        $display("FAIL strobe_width got 2+ clk want 1 clk");
      end
    end
    wr_prev = spi_wr_en;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n,
                            output logic [31:0] mv);
    mv = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      wait_clk(4);
      mv = {mv[30:0], miso};
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(4);
    chk("rst_addr", 32'(spi_addr), 32'h0);
    chk("rst_wdata", 32'(spi_wdata), 32'h0);
    chk("rst_wr_en", 32'(spi_wr_en), 32'h0);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_miso_oe", 32'(miso_oe), 32'h0);
    chk("rst_ss_n", 32'(spi_ss_n), 32'h1);
    rst = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_write();
    logic [31:0] mv;
    int c0 = wr_cnt;
    exp_q.push_back('{a: 7'h10, d: 8'hA5});
    cs_low();
    chk("wr_miso_oe", 32'(miso_oe), 32'h1);
    chk("wr_ss_n_low", 32'(spi_ss_n), 32'h0);
    shift_bits({16'h0, 1'b1, 7'h10, 8'hA5}, 16, mv);
    cs_high();
    chk("wr_addr", 32'(spi_addr), 32'h10);
    chk("wr_wdata", 32'(spi_wdata), 32'hA5);
    chk("wr_count", 32'(wr_cnt - c0), 32'd1);
    chk("wr_ss_n_high", 32'(spi_ss_n), 32'h1);
  endtask

  task automatic test_read();
    logic [31:0] mv;
    int c0 = wr_cnt;
    cs_low();
    shift_bits({16'h0, 1'b0, 7'h23, 8'h00}, 16, mv);
    cs_high();
    chk("rd_miso_data", 32'(mv[7:0]), 32'h3C);
    chk("rd_miso_cmd", 32'(mv[15:8]), 32'h00);
    chk("rd_addr", 32'(spi_addr), 32'h23);
    chk("rd_no_strobe", 32'(wr_cnt - c0), 32'd0);
    chk("rd_wdata_hold", 32'(spi_wdata), 32'hA5);
  endtask

  task automatic test_abort();
    logic [31:0] mv;
    int c0 = wr_cnt;
    cs_low();
    shift_bits({20'h0, 1'b1, 7'h0F, 4'hC}, 12, mv);
    cs_high();
    chk("ab_no_strobe", 32'(wr_cnt - c0), 32'd0);
    chk("ab_wdata_hold", 32'(spi_wdata), 32'hA5);
    chk("ab_addr_kept", 32'(spi_addr), 32'h0F);
    exp_q.push_back('{a: 7'h11, d: 8'h01});
    cs_low();
    shift_bits({16'h0, 1'b1, 7'h11, 8'h01}, 16, mv);
    cs_high();
    chk("ab_next_wdata", 32'(spi_wdata), 32'h01);
    chk("ab_next_count", 32'(wr_cnt - c0), 32'd1);
  endtask

  task automatic test_extra_bits();
    logic [31:0] mv;
    int c0 = wr_cnt;
    exp_q.push_back('{a: 7'h30, d: 8'hFF});
    cs_low();
    shift_bits({12'h0, 1'b1, 7'h30, 8'hFF, 4'hA}, 20, mv);
    cs_high();
    chk("ex_miso_extra", 32'(mv[3:0]), 32'h0);
    chk("ex_count", 32'(wr_cnt - c0), 32'd1);
    chk("ex_wdata", 32'(spi_wdata), 32'hFF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] mv;
    int c0 = wr_cnt;
    cs_low();
    shift_bits({22'h0, 1'b1, 7'h55, 2'b11}, 10, mv);
    rst = 1'b1;
    wait_clk(3);
    chk("rm_addr", 32'(spi_addr), 32'h0);
    chk("rm_wdata", 32'(spi_wdata), 32'h0);
    chk("rm_miso_oe", 32'(miso_oe), 32'h0);
    chk("rm_ss_n", 32'(spi_ss_n), 32'h1);
    cs_n = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(6);
    chk("rm_ss_n_after", 32'(spi_ss_n), 32'h1);
    chk("rm_no_strobe", 32'(wr_cnt - c0), 32'd0);
    chk("rm_miso", 32'(miso), 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] mv;
    int c0 = wr_cnt;
    exp_q.push_back('{a: 7'h44, d: 8'h3E});
    exp_q.push_back('{a: 7'h45, d: 8'hC1});
    cs_low();
    shift_bits({16'h0, 1'b1, 7'h44, 8'h3E}, 16, mv);
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(5);
    chk("bb_ss_n_gap", 32'(spi_ss_n), 32'h1);
    wait_clk(3);
    cs_low();
    chk("bb_ss_n_low", 32'(spi_ss_n), 32'h0);
    shift_bits({16'h0, 1'b1, 7'h45, 8'hC1}, 16, mv);
    cs_high();
    chk("bb_count", 32'(wr_cnt - c0), 32'd2);
    chk("bb_addr", 32'(spi_addr), 32'h45);
    chk("bb_wdata", 32'(spi_wdata), 32'hC1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_extra_bits();
    test_reset_mid();
    test_back_to_back();
    wait_clk(4);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_slave.md
SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

Interface
REQ-001 The block SHALL have parameter NB_ADDR, default 7, meaning register address width.
REQ-002 The block SHALL have parameter NB_DATA, default 8, meaning register data width.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for sclk, mosi and cs_n (legal range 2..3).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port sclk, input, 1 bit: asynchronous SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-007 The block SHALL have port cs_n, input, 1 bit: asynchronous SPI chip select, active-low.
REQ-008 The block SHALL have port mosi, input, 1 bit: asynchronous serial data in.
REQ-009 The block SHALL have port miso, output, 1 bit: serial data out.
REQ-010 The block SHALL have port miso_oe, output, 1 bit: MISO pad output enable, high while synchronized cs_n is low.
REQ-011 The block SHALL have port spi_addr, output, NB_ADDR bits: register address to the debug register file.
REQ-012 The block SHALL have port spi_wdata, output, NB_DATA bits: write data.
REQ-013 The block SHALL have port spi_wr_en, output, 1 bit: one-clk write strobe.
REQ-014 The block SHALL have port spi_ss_n, output, 1 bit: synchronized cs_n, used as the snapshot trigger downstream.
REQ-015 The block SHALL have port spi_rdata, input, NB_DATA bits: combinational read data for spi_addr.

Function
REQ-016 The frame SHALL be 1+NB_ADDR+NB_DATA bits, MSB first: RW bit (1=write, 0=read), then address, then data.
REQ-017 MOSI SHALL be sampled on each detected synchronized sclk rising edge; MISO SHALL update on each detected falling edge.
REQ-018 clk SHALL be at least 8x sclk; slower ratios are unsupported and need not be detected.
REQ-019 FSM states SHALL be IDLE, CMD, DATA and DONE.
REQ-020 IDLE SHALL go to CMD on the synchronized cs_n falling edge; the bit counter SHALL clear there.
REQ-021 CMD SHALL shift 1+NB_ADDR bits, then go to DATA.
REQ-022 On the clk after the last address bit is sampled, spi_addr SHALL update; on the following clk, spi_rdata SHALL be captured into the TX shift register.
REQ-023 In a read frame, the first falling edge in DATA SHALL drive the data MSB onto MISO.
REQ-024 Subsequent falling edges SHALL shift out the remaining bits.
REQ-025 Before the first data bit, MISO SHALL be 0.
REQ-026 In a write frame, spi_wdata SHALL load and spi_wr_en SHALL pulse high for exactly one clk, one clk after the NB_DATA-th data bit is sampled; the FSM then goes to DONE.
REQ-027 A read frame SHALL go to DONE after NB_DATA data bits, with no strobe.
REQ-028 DONE SHALL ignore further sclk edges, keep MISO at 0, and return to IDLE on the synchronized cs_n rising edge.
REQ-029 If cs_n rises in CMD or DATA, the frame SHALL abort: return to IDLE, no spi_wr_en, spi_wdata unchanged; spi_addr keeps any value already latched.
REQ-030 spi_addr and spi_wdata SHALL hold their values between frames.
REQ-031 If a cs_n rising edge and an sclk edge are detected in the same clk, the cs_n edge SHALL take priority.

Reset
REQ-032 While rst is high at a clk edge, the following SHALL hold: state=IDLE, counters=0, spi_addr=0, spi_wdata=0, spi_wr_en=0, miso=0, miso_oe=0.
REQ-033 While rst is high, synchronizer flops SHALL load the idle levels sclk=0, cs_n=1, mosi=0, so spi_ss_n=1.
REQ-034 Reset asserted mid-frame SHALL abort without a write strobe.
REQ-035 After reset releases, the block SHALL wait for a fresh cs_n falling edge.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, the RW bit encoding, and the FRAME_LEN = 1+NB_ADDR+NB_DATA derivation.
REQ-037 One sub-module, sync_edge_det (SYNC_STAGES flops plus rise/fall pulse outputs), SHALL be instantiated three times, for sclk, cs_n and mosi; the mosi instance uses its level output only.

Verification
REQ-038 Write frame 1_0010000_10100101 at sclk=clk/8 SHALL give spi_addr=0x10, spi_wdata=0xA5, and exactly one spi_wr_en pulse.
REQ-039 Read frame 0_0100011 with spi_rdata tied to 0x3C when spi_addr=0x23 SHALL shift MISO out as 00111100, with no spi_wr_en.
REQ-040 A write frame with cs_n raised after 12 bits SHALL produce no spi_wr_en and no spi_wdata change; a following valid write to 0x11 with 0x01 SHALL succeed.
REQ-041 A 20-bit write frame to 0x30 with 0xFF followed by 4 extra bits SHALL produce a single strobe, spi_wdata=0xFF, and MISO=0 during the extra bits.
REQ-042 rst pulsed at bit 10 of a write SHALL give all outputs = reset values, no strobe, and spi_ss_n=1 until cs_n is next sampled low.
REQ-043 Back-to-back frames with cs_n high for 1 sclk period SHALL both decode, and spi_ss_n SHALL toggle between them.
